// File: rtl/bias_add_sat_pipe_pkg.sv
// =============================================================================
// Module  : bias_add_sat_pipe_pkg
// Brief   : Shared widths, alignment helpers and saturation constants
// Revision: 1.0
// =============================================================================
`default_nettype none

package bias_add_sat_pipe_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_FRAC_W      = 14;
    localparam int DEF_BIAS_W      = 8;
    localparam int DEF_BIAS_FRAC_W = 6;
    localparam int DEF_CH          = 4;

    // Two guard bits above the wider operand absorb A + B and A - (-2^(BIAS_W-1)).
    function automatic int calc_sum_w(input int data_w, input int bias_w, input int align_sh);
        int wb;
        wb = bias_w + align_sh;
        return ((data_w > wb) ? data_w : wb) + 2;
    endfunction

    localparam int ALIGN_SH = DEF_FRAC_W - DEF_BIAS_FRAC_W;
    localparam int SUM_W    = calc_sum_w(DEF_DATA_W, DEF_BIAS_W, ALIGN_SH);

    localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/bias_add_sat_pipe_lane.sv
// =============================================================================
// Module  : bias_lane_sat
// Brief   : One lane: align bias, add/subtract at full width, saturate a sum
// Revision: 1.0
// =============================================================================
`default_nettype none

module bias_lane_sat
    import bias_add_sat_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BIAS_W   = DEF_BIAS_W,
    parameter int ALIGN_SH = DEF_FRAC_W - DEF_BIAS_FRAC_W,
    parameter int SUM_W    = calc_sum_w(DATA_W, BIAS_W, ALIGN_SH)
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [BIAS_W-1:0] b,
    input  logic                     sub_mode,
    output logic signed [SUM_W-1:0]  sum_full,
    input  logic signed [SUM_W-1:0]  sum_reg,
    output logic        [DATA_W-1:0] sat_sum,
    output logic                     sat_flag
);

    logic signed [SUM_W-1:0]    a_ext;
    logic signed [SUM_W-1:0]    b_al;
    logic        [SUM_W-DATA_W:0] top_bits;

    assign a_ext    = SUM_W'(a);
    assign b_al     = SUM_W'(b) <<< ALIGN_SH;
    assign sum_full = sub_mode ? (a_ext - b_al) : (a_ext + b_al);

    // The registered sum fits DATA_W only when every bit from the result sign up agrees.
    assign top_bits = sum_reg[SUM_W-1:DATA_W-1];

    always_comb begin
        sat_flag = !((&top_bits) || !(|top_bits));
        sat_sum  = sum_reg[DATA_W-1:0];
        if (sat_flag) begin
            sat_sum = {sum_reg[SUM_W-1], {(DATA_W-1){~sum_reg[SUM_W-1]}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/bias_add_sat_pipe.sv
// =============================================================================
// Module  : bias_add_sat_pipe
// Brief   : CH-lane two-stage bias add/sub with saturation and valid/ready
// Revision: 1.0
// =============================================================================
`default_nettype none

module bias_add_sat_pipe
    import bias_add_sat_pipe_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int BIAS_W      = DEF_BIAS_W,
    parameter int BIAS_FRAC_W = DEF_BIAS_FRAC_W,
    parameter int CH          = DEF_CH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sub_mode,
    input  logic [CH*DATA_W-1:0] a_vec,
    input  logic [CH*BIAS_W-1:0] b_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] sum_vec,
    output logic [CH-1:0]        sat_flags,
    output logic [CH-1:0]        ovf_sticky,
    input  logic                 clr_ovf
);

    localparam int LANE_ALIGN = FRAC_W - BIAS_FRAC_W;
    localparam int LANE_SUM_W = calc_sum_w(DATA_W, BIAS_W, LANE_ALIGN);

    if (BIAS_FRAC_W > FRAC_W) begin : g_bad_frac
        $error("bias_add_sat_pipe: BIAS_FRAC_W must not exceed FRAC_W");
    end

    logic                             s1_valid;
    logic                             s2_valid;
    logic [CH-1:0][LANE_SUM_W-1:0]    s1_sum;
    logic [CH-1:0][LANE_SUM_W-1:0]    lane_sum;
    logic [CH*DATA_W-1:0]             lane_sat;
    logic [CH-1:0]                    lane_flag;
    logic                             adv1;
    logic                             adv2;
    logic                             load2;

    // Ready looks only at pipeline state and out_ready, never at in_valid.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign load2     = adv2 && s1_valid;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        bias_lane_sat #(
            .DATA_W   (DATA_W),
            .BIAS_W   (BIAS_W),
            .ALIGN_SH (LANE_ALIGN),
            .SUM_W    (LANE_SUM_W)
        ) u_lane (
            .a        (a_vec[i*DATA_W +: DATA_W]),
            .b        (b_vec[i*BIAS_W +: BIAS_W]),
            .sub_mode (sub_mode),
            .sum_full (lane_sum[i]),
            .sum_reg  (s1_sum[i]),
            .sat_sum  (lane_sat[i*DATA_W +: DATA_W]),
            .sat_flag (lane_flag[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_sum     <= '0;
            sum_vec    <= '0;
            sat_flags  <= '0;
            ovf_sticky <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
            end
            if (adv1 && in_valid) begin
                s1_sum <= lane_sum;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            if (load2) begin
                sum_vec   <= lane_sat;
                sat_flags <= lane_flag;
            end
            // A clip landing in the same cycle as a clear survives it.
            ovf_sticky <= (clr_ovf ? '0 : ovf_sticky) | (load2 ? lane_flag : '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bias_add_sat_pipe.sv
// =============================================================================
// Module  : tb_bias_add_sat_pipe
// Brief   : Randomized + directed self-checking bench with behavioural model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_bias_add_sat_pipe;

    localparam int DATA_W = 16;
    localparam int BIAS_W = 8;
    localparam int CH     = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 sub_mode = 1'b0;
    logic [CH*DATA_W-1:0] a_vec = '0;
    logic [CH*BIAS_W-1:0] b_vec = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [CH*DATA_W-1:0] sum_vec;
    logic [CH-1:0]        sat_flags;
    logic [CH-1:0]        ovf_sticky;
    logic                 clr_ovf = 1'b0;

    bias_add_sat_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sub_mode   (sub_mode),
        .a_vec      (a_vec),
        .b_vec      (b_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum_vec    (sum_vec),
        .sat_flags  (sat_flags),
        .ovf_sticky (ovf_sticky),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*DATA_W-1:0] sum;
        logic [CH-1:0]        flags;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   cur;
    int     checks = 0;
    int     errors = 0;
    int     out_count = 0;
    logic   have_cur = 1'b0;
    logic   prev_ov = 1'b0;
    logic   prev_or = 1'b0;
    logic   prev_clr = 1'b0;
    logic [CH-1:0] m_sticky = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Real-valued intent: a has 14 fraction bits, b has 6, so b counts 2^8 units of a.
    function automatic exp_t model(input logic [CH*DATA_W-1:0] a, input logic [CH*BIAS_W-1:0] b,
                                   input logic sub);
        exp_t r;
        for (int i = 0; i < CH; i++) begin
            int av, bv, s;
            av = $signed(a[i*DATA_W +: DATA_W]);
            bv = $signed(b[i*BIAS_W +: BIAS_W]);
            bv = bv * 256;
            s  = sub ? (av - bv) : (av + bv);
            r.flags[i] = 1'b0;
            if (s > 32767) begin
                s = 32767;
                r.flags[i] = 1'b1;
            end else if (s < -32768) begin
                s = -32768;
                r.flags[i] = 1'b1;
            end
            r.sum[i*DATA_W +: DATA_W] = 16'(s);
        end
        return r;
    endfunction

    // Compare process: outputs observed mid-cycle against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_sticky = '0;
            have_cur = 1'b0;
            prev_ov  = 1'b0;
            prev_or  = 1'b0;
            prev_clr = 1'b0;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
        end else begin
            logic new_load;
            new_load = 1'b0;
            if (prev_ov && !prev_or) begin
                check("hold_valid", 64'(out_valid), 64'd1);
            end
            if (out_valid && !(prev_ov && !prev_or)) begin
                new_load = 1'b1;
                check("out_has_beat", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    out_count++;
                end else begin
                    have_cur = 1'b0;
                end
            end
            if (prev_clr) m_sticky = '0;
            if (new_load && have_cur) m_sticky = m_sticky | cur.flags;
            if (out_valid && have_cur) begin
                check("sum_vec", sum_vec, cur.sum);
                check("sat_flags", 64'(sat_flags), 64'(cur.flags));
            end
            check("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
            if (in_valid && in_ready) exp_q.push_back(model(a_vec, b_vec, sub_mode));
            prev_ov  = out_valid;
            prev_or  = out_ready;
            prev_clr = clr_ovf;
        end
    end

    task automatic send_check(input logic [15:0] a16, input logic [7:0] b8, input logic sub,
                              input logic [15:0] exp16, input logic expf, input logic clr_mid);
        @(posedge clk); #1;
        a_vec = {CH{a16}};
        b_vec = {CH{b8}};
        sub_mode = sub;
        in_valid = 1'b1;
        #1 check("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr_ovf = clr_mid;
        check("latency_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("latency_valid", 64'(out_valid), 64'd1);
        check("direct_sum", sum_vec, {CH{exp16}});
        check("direct_flags", 64'(sat_flags), 64'({CH{expf}}));
        if (clr_mid) check("clr_vs_set", 64'(ovf_sticky), 64'({CH{expf}}));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_ovf = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, stall_seen, cnt0;
        logic acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum", sum_vec, 64'd0);
        check("reset_flags", 64'(sat_flags), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed literal cases
        send_check(16'h2000, 8'h20, 1'b0, 16'h4000, 1'b0, 1'b0);
        send_check(16'h7000, 8'h40, 1'b0, 16'h7FFF, 1'b1, 1'b0);
        idle(2);
        check("sticky_hold", 64'(ovf_sticky), 64'hF);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("sticky_cleared", 64'(ovf_sticky), 64'h0);
        send_check(16'h8000, 8'h40, 1'b1, 16'h8000, 1'b1, 1'b1);
        send_check(16'h0000, 8'h80, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        idle(3);

        // Backpressure stream of 8 beats
        cnt0 = out_count;
        k = 0;
        stall_seen = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (k < 8);
            a_vec     = {CH{16'(k * 256)}};
            b_vec     = '0;
            sub_mode  = 1'b0;
            #1;
            if (!in_ready) stall_seen++;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
        end
        idle(4);
        check("bp_accepted", 64'(k), 64'd8);
        check("bp_outputs", 64'(out_count - cnt0), 64'd8);
        check("bp_stall_seen", 64'(stall_seen != 0), 64'd1);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Randomized traffic
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a_vec    = {$urandom, $urandom};
                b_vec    = $urandom;
                sub_mode = $urandom_range(0, 1);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        idle(6);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        a_vec = {CH{16'h7000}};
        b_vec = {CH{8'h40}};
        sub_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a_vec = {CH{16'h1000}};
        b_vec = '0;
        @(posedge clk); #1;
        check("pre_rst_sticky", 64'(ovf_sticky), 64'hF);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_sum", sum_vec, 64'd0);
        check("rst_mid_sticky", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("no_stale_beat", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
